tx_frame_ctrl: RTL and testbench
================================

TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, 16, clk cycles per UART bit period; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 tx_data  input  8  payload byte, LSB transmitted first.
REQ-005 tx_valid  input  1  upstream offers tx_data this cycle.
REQ-006 tx_ready  output  1  block accepts a byte this cycle.
REQ-007 uart_data_width  input  UART_FRAME_SIZE  data bits per frame, 5..8.
REQ-008 tx_byte  output  tx_byte_stop  assembled frame vector for the downstream shifter.
REQ-009 tx_index  output  UART_FRAME_SIZE  bit position currently on the line.
REQ-010 tx_shift  output  1  one-cycle pulse at each bit-period boundary.
REQ-011 tx_busy  output  1  frame in progress.
REQ-012 tx_done  output  1  one-cycle pulse after the last stop-bit period.

Function
REQ-013 FSM states IDLE, START, DATA, PARITY, STOP; encoding from package enum.
REQ-014 tx_ready = 1 only in IDLE; handshake completes when tx_valid & tx_ready on a rising edge.
REQ-015 On handshake: latch tx_data and uart_data_width, build tx_byte, go to START, clear baud counter, tx_index = 0.
REQ-016 Frame layout: tx_byte[0] = 0 (start), [1..W] = data LSB first, then parity bit if enabled, then stop bit = 1; unused upper bits = 1.
REQ-017 uart_data_width outside 5..8 is treated as 8; width change while busy has no effect on the current frame.
REQ-018 Baud counter counts 0..CLKS_PER_BIT-1; tx_shift pulses on the cycle counter == CLKS_PER_BIT-1.
REQ-019 On each tx_shift, tx_index increments by 1 and FSM advances: START->DATA; DATA->DATA until W data bits sent; last DATA->PARITY (if enabled) else STOP; PARITY->STOP; STOP->IDLE.
REQ-020 Every state lasts exactly CLKS_PER_BIT cycles; total frame = (W+2[+1]) x CLKS_PER_BIT cycles from handshake to tx_done.
REQ-021 tx_done pulses in the cycle STOP exits to IDLE; tx_ready rises in the following cycle.
REQ-022 tx_busy = 1 in every state except IDLE.
REQ-023 tx_byte and tx_index held stable for the whole frame except tx_index steps; in IDLE tx_index = 0 and tx_byte = all ones (line idle high).
REQ-024 tx_valid while busy is ignored; no byte is lost because tx_ready is 0.

Reset
REQ-025 n_rst low forces IDLE, counter 0, tx_index 0, tx_byte all ones, tx_shift 0, tx_done 0, tx_busy 0, tx_ready 0 while asserted.
REQ-026 Reset mid-frame aborts the frame immediately; no tx_done; tx_ready = 1 on first cycle after release.

Configuration
REQ-027 Macro UART_MIKE_PARITY_EN defined: PARITY state present, even parity of the W data bits inserted after data, frame = W+3 bits.
REQ-028 Macro undefined: PARITY state and logic absent, frame = W+2 bits, DATA goes straight to STOP.

Structure
REQ-029 UART_MIKE_pkg holds UART_DATA_SIZE, UART_FRAME_SIZE, UART_FRAME_WIDHT, tx_byte_stop typedef and the tx FSM state enum.
REQ-030 Baud counter is a sub-module baud_gen (inputs clk, n_rst, clear; output tick), parameterised by CLKS_PER_BIT.
REQ-031 Flops use the shared MIKE_FF_NRST macro from UART_MIKE_header.svh.

Verification
REQ-032 Reset release, tx_valid=0 -> tx_ready=1, tx_busy=0, tx_index=0, tx_byte all ones, no tx_shift.
REQ-033 CLKS_PER_BIT=4, W=8, data 0xA5, no parity -> tx_byte bits 0..9 = 0,1,0,1,0,0,1,0,1,1; tx_done 40 cycles after handshake.
REQ-034 UART_MIKE_PARITY_EN, W=7, data 0x53 -> parity bit 0 at index 8, stop at index 9, tx_done after 10 bit periods.
REQ-035 uart_data_width=3 with data 0xFF -> treated as W=8, 10-bit frame.
REQ-036 tx_valid held high continuously -> back-to-back frames, exactly one idle cycle (tx_ready=1) between tx_done and next START.
REQ-037 n_rst pulsed low during DATA index 4 -> outputs at reset values, no tx_done, next byte accepted and sent intact.

Source files
------------

// File: rtl/tx_frame_ctrl_pkg.sv
// Shared types, constants and frame-building helpers for the UART transmit framer.
// Optional parity is enabled by defining UART_MIKE_PARITY_EN.

`ifndef MIKE_FF_NRST
`define MIKE_FF_NRST(q, d, rst_val) \
  always_ff @(posedge clk or negedge n_rst) \
    if (!n_rst) q <= (rst_val); \
    else q <= (d);
`endif

package UART_MIKE_pkg;

  localparam int UART_DATA_SIZE   = 8;
  localparam int UART_FRAME_SIZE  = 4;
  localparam int UART_FRAME_WIDHT = UART_DATA_SIZE + 3;

  typedef logic [UART_FRAME_WIDHT-1:0] tx_byte_stop;

`ifdef UART_MIKE_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

  // Widths outside 5..8 fall back to a full byte.
  function automatic logic [UART_FRAME_SIZE-1:0] eff_width(input logic [UART_FRAME_SIZE-1:0] w);
    return (w < UART_FRAME_SIZE'(5) || w > UART_FRAME_SIZE'(8)) ? UART_FRAME_SIZE'(8) : w;
  endfunction

  // Start bit at [0], data LSB first, optional even parity, then ones (stop and idle fill).
  function automatic tx_byte_stop build_frame(input logic [UART_DATA_SIZE-1:0] data,
                                              input logic [UART_FRAME_SIZE-1:0] w);
    tx_byte_stop f;
`ifdef UART_MIKE_PARITY_EN
    logic par;
    par = 1'b0;
`endif
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < UART_DATA_SIZE; i++) begin
      if (i < int'(w)) begin
        f[i+1] = data[i];
`ifdef UART_MIKE_PARITY_EN
        par = par ^ data[i];
`endif
      end
    end
`ifdef UART_MIKE_PARITY_EN
    for (int i = 5; i <= UART_DATA_SIZE; i++) begin
      if (i == int'(w)) f[i+1] = par;
    end
`endif
    return f;
  endfunction

endpackage

// File: rtl/tx_frame_ctrl_if.sv
// Upstream byte handshake between a producer and the transmit framer.

interface tx_frame_ctrl_if;
  import UART_MIKE_pkg::*;

  logic [UART_DATA_SIZE-1:0]  tx_data;
  logic                       tx_valid;
  logic                       tx_ready;
  logic [UART_FRAME_SIZE-1:0] uart_data_width;

  modport master (output tx_data, output tx_valid, output uart_data_width, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, input  uart_data_width, output tx_ready);
endinterface

// File: rtl/tx_frame_ctrl_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.

module baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  assign tick      = (count == LAST);
  assign count_nxt = (clear || tick) ? '0 : count + 1'b1;

  `MIKE_FF_NRST(count, count_nxt, '0)

endmodule

// File: rtl/tx_frame_ctrl.sv
// UART transmit frame controller: accepts a byte, builds the frame vector and
// sequences bit periods. Optional even parity via UART_MIKE_PARITY_EN.

module tx_frame_ctrl
  import UART_MIKE_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       n_rst,
  tx_frame_ctrl_if.slave             up,
  output tx_byte_stop                tx_byte,
  output logic [UART_FRAME_SIZE-1:0] tx_index,
  output logic                       tx_shift,
  output logic                       tx_busy,
  output logic                       tx_done
);

  tx_state_e                  state;
  logic [UART_FRAME_SIZE-1:0] width_q;
  logic                       tick;
  logic                       baud_clear;
  logic                       handshake;

  // Ready is gated by reset so it reads 0 during reset and 1 as soon as it releases.
  assign tx_busy    = (state != IDLE);
  assign up.tx_ready = (state == IDLE) && n_rst;
  assign handshake  = up.tx_valid && up.tx_ready;
  assign tx_shift   = tick && tx_busy;
  assign tx_done    = tx_shift && (state == STOP);
  assign baud_clear = !tx_busy;

  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_gen (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking (<=).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      tx_byte  <= '1;
      tx_index <= '0;
      width_q  <= UART_FRAME_SIZE'(UART_DATA_SIZE);
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            width_q  <= eff_width(up.uart_data_width);
            tx_byte  <= build_frame(up.tx_data, eff_width(up.uart_data_width));
            tx_index <= '0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_index <= tx_index + 1'b1;
            state    <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            tx_index <= tx_index + 1'b1;
            // Data bits occupy indices 1..W, so index W is the last one.
            if (tx_index == width_q) begin
`ifdef UART_MIKE_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_MIKE_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx_index <= tx_index + 1'b1;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            tx_index <= '0;
            tx_byte  <= '1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed self-checking bench for tx_frame_ctrl (CLKS_PER_BIT = 4); expected
// frame vectors follow the build selected by UART_MIKE_PARITY_EN.

module tb_tx_frame_ctrl;
  import UART_MIKE_pkg::*;

  localparam int CPB = 4;

`ifdef UART_MIKE_PARITY_EN
  localparam int P = 1;
  localparam tx_byte_stop F_A5   = 11'h54A;
  localparam tx_byte_stop F_FF   = 11'h5FE;
  localparam tx_byte_stop F_3C   = 11'h478;
  localparam tx_byte_stop F_0F   = 11'h41E;
  localparam tx_byte_stop F_F0   = 11'h5E0;
  localparam tx_byte_stop F_53W7 = 11'h6A6;
  localparam tx_byte_stop F_E3W5 = 11'h786;
`else
  localparam int P = 0;
  localparam tx_byte_stop F_A5   = 11'h74A;
  localparam tx_byte_stop F_FF   = 11'h7FE;
  localparam tx_byte_stop F_3C   = 11'h678;
  localparam tx_byte_stop F_0F   = 11'h61E;
  localparam tx_byte_stop F_F0   = 11'h7E0;
  localparam tx_byte_stop F_53W7 = 11'h7A6;
  localparam tx_byte_stop F_E3W5 = 11'h7C6;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  tx_frame_ctrl_if bus ();
  tx_byte_stop tx_byte;
  logic [UART_FRAME_SIZE-1:0] tx_index;
  logic tx_shift, tx_busy, tx_done;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_frame_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .up       (bus),
    .tx_byte  (tx_byte),
    .tx_index (tx_index),
    .tx_shift (tx_shift),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, "/ready"}, bus.tx_ready, 1);
    check({tag, "/busy"},  tx_busy, 0);
    check({tag, "/index"}, tx_index, 0);
    check({tag, "/byte"},  tx_byte, 11'h7FF);
    check({tag, "/shift"}, tx_shift, 0);
  endtask

  // Handshake at the next rising edge; returns at the falling edge of cycle 1.
  task automatic send(input logic [7:0] d, input logic [3:0] w);
    check("ready_before_send", bus.tx_ready, 1);
    bus.tx_data         = d;
    bus.uart_data_width = w;
    bus.tx_valid        = 1'b1;
    @(negedge clk);
    bus.tx_valid        = 1'b0;
    bus.tx_data         = 8'h00;
    bus.uart_data_width = 4'd5;
  endtask

  // Starts at cycle 1 of a frame; returns at the falling edge of the tx_done cycle.
  task automatic watch_frame(input string tag, input tx_byte_stop exp_byte, input int exp_bits);
    int c, done_c, shifts, bad;
    c = 1; done_c = -1; shifts = 0; bad = 0;
    while (done_c < 0 && c <= 1000) begin
      if (tx_byte !== exp_byte || tx_busy !== 1'b1 || bus.tx_ready !== 1'b0) bad++;
      if (tx_shift === 1'b1) begin
        if (tx_index !== 4'(shifts)) bad++;
        shifts++;
      end
      if (tx_done === 1'b1) done_c = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    check({tag, "/done_cycle"}, done_c, exp_bits * CPB);
    check({tag, "/shifts"}, shifts, exp_bits);
    check({tag, "/stable_bad"}, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    bus.tx_valid        = 1'b0;
    bus.tx_data         = 8'h00;
    bus.uart_data_width = 4'd8;
    n_rst               = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/ready", bus.tx_ready, 0);
    check("rst/busy",  tx_busy, 0);
    check("rst/byte",  tx_byte, 11'h7FF);
    check("rst/index", tx_index, 0);
    check("rst/done",  tx_done, 0);

    n_rst = 1'b1;
    @(negedge clk);
    idle_check("post_reset");
    cnt = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (tx_shift !== 1'b0 || tx_busy !== 1'b0) cnt++;
    end
    check("idle_quiet", cnt, 0);

    send(8'hA5, 4'd8);
    watch_frame("a5_w8", F_A5, 10 + P);
    @(negedge clk); idle_check("a5_after");

    send(8'h53, 4'd7);
    watch_frame("53_w7", F_53W7, 9 + P);
    @(negedge clk); idle_check("53_after");

    send(8'hE3, 4'd5);
    watch_frame("e3_w5", F_E3W5, 7 + P);
    @(negedge clk); idle_check("e3_after");

    send(8'hFF, 4'd3);
    watch_frame("ff_w3", F_FF, 10 + P);
    @(negedge clk); idle_check("ff_after");

    // Back-to-back with tx_valid held high; the second byte is offered while busy.
    bus.tx_data         = 8'h0F;
    bus.uart_data_width = 4'd8;
    bus.tx_valid        = 1'b1;
    @(negedge clk);
    bus.tx_data = 8'hF0;
    watch_frame("b2b_a", F_0F, 10 + P);
    @(negedge clk);
    check("b2b_gap/ready", bus.tx_ready, 1);
    check("b2b_gap/busy",  tx_busy, 0);
    @(negedge clk);
    check("b2b_next/busy",  tx_busy, 1);
    check("b2b_next/ready", bus.tx_ready, 0);
    check("b2b_next/byte",  tx_byte, F_F0);
    check("b2b_next/index", tx_index, 0);
    bus.tx_valid = 1'b0;
    watch_frame("b2b_b", F_F0, 10 + P);
    @(negedge clk); idle_check("b2b_after");

    // Reset while the fourth data bit (index 4) is on the line.
    send(8'hA5, 4'd8);
    repeat (17) @(negedge clk);
    check("mid/index", tx_index, 4);
    check("mid/busy",  tx_busy, 1);
    n_rst = 1'b0;
    #1;
    check("abort/byte",  tx_byte, 11'h7FF);
    check("abort/index", tx_index, 0);
    check("abort/busy",  tx_busy, 0);
    check("abort/ready", bus.tx_ready, 0);
    check("abort/shift", tx_shift, 0);
    check("abort/done",  tx_done, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("release/ready", bus.tx_ready, 1);
    check("release/busy",  tx_busy, 0);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 12 * CPB; i++) begin
      if (tx_done !== 1'b0 || tx_busy !== 1'b0) cnt++;
      @(negedge clk);
    end
    check("no_done_after_abort", cnt, 0);

    send(8'h3C, 4'd8);
    watch_frame("3c_w8", F_3C, 10 + P);
    @(negedge clk); idle_check("3c_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
